// File: rtl/spc_irq_pkg.sv
// Shared types and helpers for the SPC700 interrupt controller.
package spc_irq_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} irq_state_e;

  localparam int          IRQ_NCH_DFLT      = 4;
  localparam logic [15:0] IRQ_VEC_BASE_DFLT = 16'hFFC0;
  // The slot just past the last channel vector is the spurious-ACK vector.
  localparam int          SPUR_OFS          = 2 * IRQ_NCH_DFLT;

  // Two-byte vector slots; 16-bit wrap is intentional.
  function automatic logic [15:0] vec_of(input logic [15:0] base, input int unsigned id);
    return base + 16'(2 * id);
  endfunction

endpackage

// File: rtl/spc_irq_prio_enc.sv
// Lowest-index-wins priority encoder.
module spc_irq_prio_enc #(
  parameter int NCH = 4,
  parameter int IDW = 3
) (
  input  logic [NCH-1:0] req,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NCH - 1; i >= 0; i--)
      if (req[i]) idx = IDW'(i);
  end

endmodule

// File: rtl/spc_irq_ctrl.sv
// Multi-channel fixed-priority interrupt controller in front of the SPC700 core.
// Define SPC_IRQ_NEST_EN for priority nesting; default is single-level service.
module spc_irq_ctrl
  import spc_irq_pkg::*;
#(
  parameter int          NCH      = IRQ_NCH_DFLT,
  parameter int          IDW      = 3,
  parameter logic [15:0] VEC_BASE = IRQ_VEC_BASE_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] irq_src,
  input  logic [NCH-1:0] edge_mode,
  input  logic [NCH-1:0] mask,
  input  logic           ack,
  input  logic           eoi,
  input  logic [IDW-1:0] eoi_id,
  output logic           irq_n,
  output logic [15:0]    vec_addr,
  output logic [IDW-1:0] ack_id,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] in_service
);

  localparam logic [15:0] VEC_SPUR = vec_of(VEC_BASE, NCH);

  irq_state_e     state, state_nx;
  logic [NCH-1:0] src_q, pend_edge, rise, ack_clr, is_set, eoi_clr, allow, elig;
  logic           win_vld, irq_n_nx;
  logic [IDW-1:0] win_idx, ack_id_nx;
  logic [15:0]    vec_nx;

  assign rise    = irq_src & ~src_q & edge_mode;
  assign pending = (edge_mode & pend_edge) | (~edge_mode & src_q);

`ifdef SPC_IRQ_NEST_EN
  logic           is_vld;
  logic [IDW-1:0] is_idx;

  spc_irq_prio_enc #(.NCH(NCH), .IDW(IDW)) u_is_enc (
    .req   (in_service),
    .valid (is_vld),
    .idx   (is_idx)
  );

  // Only strictly higher priority than the most urgent in-service channel may nest.
  always_comb begin
    allow = '0;
    for (int i = 0; i < NCH; i++)
      allow[i] = !is_vld || (IDW'(i) < is_idx);
  end
`else
  assign allow = {NCH{~|in_service}};
`endif

  assign elig = pending & ~mask & allow;

  spc_irq_prio_enc #(.NCH(NCH), .IDW(IDW)) u_win_enc (
    .req   (elig),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // Out-of-range EOI_ID decodes to nothing.
  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NCH; i++)
      if (eoi_id == IDW'(i)) eoi_clr[i] = en & eoi;
  end

  always_comb begin
    state_nx  = state;
    irq_n_nx  = irq_n;
    vec_nx    = vec_addr;
    ack_id_nx = ack_id;
    is_set    = '0;
    ack_clr   = '0;
    if (en) begin
      case (state)
        IDLE: begin
          irq_n_nx = 1'b1;
          if (win_vld) begin
            vec_nx   = vec_of(VEC_BASE, 32'(win_idx));
            irq_n_nx = 1'b0;
            state_nx = ASSERT;
          end
        end
        ASSERT: begin
          irq_n_nx = 1'b0;
          if (ack) begin
            irq_n_nx = 1'b1;
            state_nx = HOLD;
            if (win_vld) begin
              vec_nx           = vec_of(VEC_BASE, 32'(win_idx));
              ack_id_nx        = win_idx;
              is_set[win_idx]  = 1'b1;
              ack_clr[win_idx] = 1'b1;
            end else begin
              vec_nx = VEC_SPUR;
            end
          end else if (!win_vld) begin
            irq_n_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            vec_nx = vec_of(VEC_BASE, 32'(win_idx));
          end
        end
        HOLD: begin
          irq_n_nx = 1'b1;
          state_nx = IDLE;
        end
        default: begin
          irq_n_nx = 1'b1;
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq_n      <= 1'b1;
      vec_addr   <= VEC_SPUR;
      ack_id     <= '0;
      src_q      <= '0;
      pend_edge  <= '0;
      in_service <= '0;
    end else begin
      state      <= state_nx;
      irq_n      <= irq_n_nx;
      vec_addr   <= vec_nx;
      ack_id     <= ack_id_nx;
      src_q      <= irq_src;
      // A fresh edge beats a simultaneous ACK clear; an ACK set beats EOI.
      pend_edge  <= rise | (pend_edge & ~ack_clr);
      in_service <= (in_service & ~eoi_clr) | is_set;
    end
  end

endmodule

// File: tb/tb_spc_irq_ctrl.sv
// Directed-vector bench for spc_irq_ctrl (NCH=4, VEC_BASE=FFC0).
module tb_spc_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, ack, eoi;
  logic [3:0] irq_src, edge_mode, mask;
  logic [2:0] eoi_id;
  logic       irq_n;
  logic [15:0] vec_addr;
  logic [2:0] ack_id;
  logic [3:0] pending, in_service;

  int checks = 0;
  int passed = 0;

  spc_irq_ctrl #(.NCH(4), .IDW(3), .VEC_BASE(16'hFFC0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .irq_src    (irq_src),
    .edge_mode  (edge_mode),
    .mask       (mask),
    .ack        (ack),
    .eoi        (eoi),
    .eoi_id     (eoi_id),
    .irq_n      (irq_n),
    .vec_addr   (vec_addr),
    .ack_id     (ack_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; ack = 1'b0; eoi = 1'b0; eoi_id = '0;
    irq_src = '0; edge_mode = '0; mask = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ack = 1'b0; eoi = 1'b0; eoi_id = '0;
    irq_src = '0; edge_mode = '0; mask = '0;
    tick(); tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL reset_irq_n got %b want 1", irq_n); else passed++;
    checks++; if (vec_addr !== 16'hFFC8) $display("FAIL reset_vec got %h want ffc8", vec_addr); else passed++;
    checks++; if (ack_id !== 3'd0) $display("FAIL reset_ack_id got %0d want 0", ack_id); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL reset_pending got %b want 0000", pending); else passed++;
    checks++; if (in_service !== 4'b0000) $display("FAIL reset_in_service got %b want 0000", in_service); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_edge();
    do_reset();
    edge_mode = 4'b0100;
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    checks++; if (pending !== 4'b0100) $display("FAIL edge_pending got %b want 0100", pending); else passed++;
    checks++; if (irq_n !== 1'b1) $display("FAIL edge_irq_n_early got %b want 1", irq_n); else passed++;
    tick();
    checks++; if (irq_n !== 1'b0) $display("FAIL edge_irq_n_low got %b want 0", irq_n); else passed++;
    checks++; if (vec_addr !== 16'hFFC4) $display("FAIL edge_vec got %h want ffc4", vec_addr); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (ack_id !== 3'd2) $display("FAIL edge_ack_id got %0d want 2", ack_id); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL edge_pending_clr got %b want 0000", pending); else passed++;
    checks++; if (in_service !== 4'b0100) $display("FAIL edge_in_service got %b want 0100", in_service); else passed++;
    checks++; if (irq_n !== 1'b1) $display("FAIL edge_hold_irq_n got %b want 1", irq_n); else passed++;
    tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL edge_idle_irq_n got %b want 1", irq_n); else passed++;
    eoi = 1'b1; eoi_id = 3'd2;
    tick();
    eoi = 1'b0;
    checks++; if (in_service !== 4'b0000) $display("FAIL edge_eoi got %b want 0000", in_service); else passed++;
  endtask

  task automatic test_level();
    do_reset();
    irq_src = 4'b1010;
    tick();
    checks++; if (pending !== 4'b1010) $display("FAIL level_pending got %b want 1010", pending); else passed++;
    tick();
    checks++; if (vec_addr !== 16'hFFC2) $display("FAIL level_vec got %h want ffc2", vec_addr); else passed++;
    checks++; if (irq_n !== 1'b0) $display("FAIL level_irq_n got %b want 0", irq_n); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (in_service !== 4'b0010) $display("FAIL level_in_service got %b want 0010", in_service); else passed++;
    checks++; if (pending !== 4'b1010) $display("FAIL level_pending_kept got %b want 1010", pending); else passed++;
    checks++; if (ack_id !== 3'd1) $display("FAIL level_ack_id got %0d want 1", ack_id); else passed++;
    irq_src = 4'b1000;
    tick(); tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL level_blocked got %b want 1", irq_n); else passed++;
    eoi = 1'b1; eoi_id = 3'd5;
    tick();
    checks++; if (in_service !== 4'b0010) $display("FAIL level_eoi_oor got %b want 0010", in_service); else passed++;
    eoi_id = 3'd1;
    tick();
    eoi = 1'b0;
    checks++; if (in_service !== 4'b0000) $display("FAIL level_eoi got %b want 0000", in_service); else passed++;
    tick();
    checks++; if (irq_n !== 1'b0) $display("FAIL level_ch3_irq_n got %b want 0", irq_n); else passed++;
    checks++; if (vec_addr !== 16'hFFC6) $display("FAIL level_ch3_vec got %h want ffc6", vec_addr); else passed++;
  endtask

  task automatic test_nesting();
    logic exp_ch0;
`ifdef SPC_IRQ_NEST_EN
    exp_ch0 = 1'b0;
`else
    exp_ch0 = 1'b1;
`endif
    do_reset();
    irq_src = 4'b0100;
    tick(); tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (in_service !== 4'b0100) $display("FAIL nest_in_service got %b want 0100", in_service); else passed++;
    irq_src = 4'b1000;
    tick(); tick(); tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL nest_ch3_blocked got %b want 1", irq_n); else passed++;
    irq_src = 4'b1001;
    tick(); tick();
    checks++; if (irq_n !== exp_ch0) $display("FAIL nest_ch0_irq_n got %b want %b", irq_n, exp_ch0); else passed++;
    if (!exp_ch0) begin
      checks++; if (vec_addr !== 16'hFFC0) $display("FAIL nest_ch0_vec got %h want ffc0", vec_addr); else passed++;
    end
  endtask

  task automatic test_mask_drop();
    do_reset();
    irq_src = 4'b0100;
    tick(); tick();
    checks++; if (irq_n !== 1'b0) $display("FAIL mask_assert got %b want 0", irq_n); else passed++;
    mask = 4'b0100;
    tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL mask_deassert got %b want 1", irq_n); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (vec_addr !== 16'hFFC4) $display("FAIL mask_late_ack_vec got %h want ffc4", vec_addr); else passed++;
    checks++; if (in_service !== 4'b0000) $display("FAIL mask_late_ack_is got %b want 0000", in_service); else passed++;
    checks++; if (pending !== 4'b0100) $display("FAIL mask_pending got %b want 0100", pending); else passed++;
  endtask

  task automatic test_spurious();
    do_reset();
    irq_src = 4'b0100;
    tick(); tick();
    mask = 4'b0100; ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (vec_addr !== 16'hFFC8) $display("FAIL spur_vec got %h want ffc8", vec_addr); else passed++;
    checks++; if (ack_id !== 3'd0) $display("FAIL spur_ack_id got %0d want 0", ack_id); else passed++;
    checks++; if (in_service !== 4'b0000) $display("FAIL spur_is got %b want 0000", in_service); else passed++;
    checks++; if (irq_n !== 1'b1) $display("FAIL spur_irq_n got %b want 1", irq_n); else passed++;
  endtask

  task automatic test_preempt();
    do_reset();
    edge_mode = 4'b1111;
    irq_src = 4'b1000;
    tick();
    irq_src = 4'b0000;
    tick();
    checks++; if (vec_addr !== 16'hFFC6) $display("FAIL preempt_vec3 got %h want ffc6", vec_addr); else passed++;
    irq_src = 4'b0010;
    tick(); tick();
    irq_src = 4'b0000;
    checks++; if (vec_addr !== 16'hFFC2) $display("FAIL preempt_vec1 got %h want ffc2", vec_addr); else passed++;
    checks++; if (irq_n !== 1'b0) $display("FAIL preempt_irq_n got %b want 0", irq_n); else passed++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (ack_id !== 3'd1) $display("FAIL preempt_ack_id got %0d want 1", ack_id); else passed++;
    checks++; if (pending !== 4'b1000) $display("FAIL preempt_pending got %b want 1000", pending); else passed++;
    checks++; if (in_service !== 4'b0010) $display("FAIL preempt_is got %b want 0010", in_service); else passed++;
  endtask

  task automatic test_en_freeze();
    do_reset();
    edge_mode = 4'b0001;
    en = 1'b0;
    irq_src = 4'b0001;
    tick();
    irq_src = 4'b0000;
    tick(); tick(); tick(); tick();
    checks++; if (pending !== 4'b0001) $display("FAIL en_pending got %b want 0001", pending); else passed++;
    checks++; if (irq_n !== 1'b1) $display("FAIL en_frozen got %b want 1", irq_n); else passed++;
    en = 1'b1;
    tick();
    checks++; if (irq_n !== 1'b0) $display("FAIL en_advance got %b want 0", irq_n); else passed++;
    checks++; if (vec_addr !== 16'hFFC0) $display("FAIL en_vec got %h want ffc0", vec_addr); else passed++;
    en = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (in_service !== 4'b0000) $display("FAIL en_ack_ignored got %b want 0000", in_service); else passed++;
    checks++; if (irq_n !== 1'b0) $display("FAIL en_assert_held got %b want 0", irq_n); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (irq_n !== 1'b1) $display("FAIL rst_irq_n got %b want 1", irq_n); else passed++;
    checks++; if (vec_addr !== 16'hFFC8) $display("FAIL rst_vec got %h want ffc8", vec_addr); else passed++;
    checks++; if (pending !== 4'b0000) $display("FAIL rst_pending got %b want 0000", pending); else passed++;
    en = 1'b1;
    tick();
    checks++; if (irq_n !== 1'b1) $display("FAIL rst_idle got %b want 1", irq_n); else passed++;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_nesting();
    test_mask_drop();
    test_spurious();
    test_preempt();
    test_en_freeze();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
